// File: rtl/mac_vec_pack.sv
// Packs a stream of (a, b) element pairs into LANES-wide vector pairs for a MAC.
// A vector closes when it is full or when flush is seen, and is held until the consumer takes it.
module mac_vec_pack #(
  parameter int LANES = 8,
  parameter int BW    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW-1:0]            in_a,
  input  logic [BW-1:0]            in_b,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BW-1:0]      out_a,
  output logic [LANES*BW-1:0]      out_b,
  output logic [$clog2(LANES):0]   out_count
);

  localparam int CW = $clog2(LANES) + 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       out_count_q, out_count_d;
  logic [LANES*BW-1:0] a_q, a_d, b_q, b_d;

  logic                accept_s, drain_s, open_s, close_s;
  logic [CW-1:0]       base_cnt_s, next_cnt_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Packing registers double as the held output vector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= {CW{1'b0}};
      out_count_q <= {CW{1'b0}};
      a_q         <= {(LANES*BW){1'b0}};
      b_q         <= {(LANES*BW){1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    accept_s    = in_valid && in_ready;
    drain_s     = out_valid && out_ready;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_count_d = out_count_q;
    a_d         = a_q;
    b_d         = b_q;
    base_cnt_s  = cnt_q;
    next_cnt_s  = cnt_q;
    close_s     = 1'b0;

    case (state_q)
      FILL:    open_s = 1'b1;
      FULL:    open_s = drain_s;
      default: open_s = 1'b0;
    endcase

    if (open_s) begin
      // Leaving FULL starts a fresh, zeroed vector so unfilled lanes read as 0
      if (state_q == FULL) begin
        a_d        = {(LANES*BW){1'b0}};
        b_d        = {(LANES*BW){1'b0}};
        base_cnt_s = {CW{1'b0}};
      end else begin
        base_cnt_s = cnt_q;
      end

      if (accept_s) begin
        for (int k = 0; k < LANES; k++) begin
          if (base_cnt_s == CW'(k)) begin
            a_d[k*BW +: BW] = in_a;
            b_d[k*BW +: BW] = in_b;
          end else begin
            a_d[k*BW +: BW] = a_d[k*BW +: BW];
            b_d[k*BW +: BW] = b_d[k*BW +: BW];
          end
        end
        next_cnt_s = base_cnt_s + CW'(1);
      end else begin
        next_cnt_s = base_cnt_s;
      end

      // Flush never closes an empty vector
      close_s = (next_cnt_s == CW'(LANES)) || (flush && (next_cnt_s != {CW{1'b0}}));

      if (close_s) begin
        state_d     = FULL;
        cnt_d       = {CW{1'b0}};
        out_count_d = next_cnt_s;
      end else begin
        state_d     = FILL;
        cnt_d       = next_cnt_s;
        out_count_d = {CW{1'b0}};
      end
    end else begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_count_d = out_count_q;
    end
  end

  // Output decode
  always_comb begin
    case (state_q)
      FILL:    out_valid = 1'b0;
      FULL:    out_valid = 1'b1;
      default: out_valid = 1'b0;
    endcase
    in_ready  = !out_valid || out_ready;
    out_a     = a_q;
    out_b     = b_q;
    out_count = out_count_q;
  end

endmodule

// File: doc/mac_vec_pack.md
MAC_VEC_PACK -- requirements
Module: mac_vec_pack

Interface
REQ-001 SHALL have parameter LANES, default 8, number of vector elements per packed output vector.
REQ-002 SHALL have parameter BW, default 8, bit width of each element.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer presents an element pair.
REQ-006 SHALL have port in_ready  output  1  block accepts the element pair this cycle.
REQ-007 SHALL have port in_a  input  BW  element of vector A.
REQ-008 SHALL have port in_b  input  BW  element of vector B.
REQ-009 SHALL have port flush  input  1  close the current partial vector and zero-pad the remaining lanes.
REQ-010 SHALL have port out_valid  output  1  packed vector pair is available to the MAC.
REQ-011 SHALL have port out_ready  input  1  MAC side consumes the vector pair this cycle.
REQ-012 SHALL have port out_a  output  LANES*BW  packed A; element k occupies bits [BW*k+BW-1 : BW*k].
REQ-013 SHALL have port out_b  output  LANES*BW  packed B; same lane mapping as out_a.
REQ-014 SHALL have port out_count  output  $clog2(LANES)+1  number of valid lanes in the presented vector (1..LANES).

Function
REQ-015 SHALL implement a two-state FSM: FILL (collecting elements) and FULL (vector held at the output).
REQ-016 SHALL transfer an input element only when in_valid && in_ready are both high at a rising edge.
REQ-017 SHALL transfer an output vector only when out_valid && out_ready are both high at a rising edge.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, so the block can drain and accept in the same cycle.
REQ-019 SHALL write the element of the k-th accepted transfer since vector start into lane k, where k counts from 0.
REQ-020 SHALL zero the packing registers and the lane counter when a new vector starts, so unfilled lanes are always 0.
REQ-021 SHALL assert out_valid on the cycle after lane LANES-1 is written, with out_count = LANES, and enter FULL.
REQ-022 SHALL, when flush is sampled high in FILL with a lane count > 0, enter FULL with out_count = lane count and the remaining lanes zero.
REQ-023 SHALL, when flush and an accepted element coincide, write the element first and then close the vector, with out_count = lane count + 1.
REQ-024 SHALL ignore flush when the lane count is 0 and no element is accepted in the same cycle; no empty vector is ever emitted.
REQ-025 SHALL ignore flush in FULL unless the same cycle both drains the vector and accepts an element; in that case the flush applies to the new vector.
REQ-026 SHALL hold out_a, out_b and out_count stable while out_valid && !out_ready.
REQ-027 SHALL, on a drain without a simultaneous accept, deassert out_valid on the next cycle and return to FILL with lane count 0.
REQ-028 SHALL, on a drain with a simultaneous accept, place the new element in lane 0 of a fresh zeroed vector.
REQ-029 SHALL have a latency of 1 cycle from the last accepted (or flush-closing) element to out_valid; throughput SHALL be one element per cycle with no bubble between vectors when out_ready stays high.
REQ-030 SHALL be width-safe: with defaults, a full vector feeds an 8-lane MAC whose 19-bit sum of 255*255*8 does not overflow.

Reset
REQ-031 SHALL, while reset_n is low, immediately force state = FILL, lane count = 0, out_valid = 0, out_a = 0, out_b = 0 and out_count = 0.
REQ-032 SHALL discard any partial or held vector when reset is asserted mid-operation, and SHALL emit nothing stale after release.
REQ-033 SHALL drive in_ready = 1 during and immediately after reset.

Verification
REQ-034 SHALL cover: 8 accepts (a = 1..8, b = 0x10..0x17) with out_ready = 1 -> one cycle later out_valid = 1, out_a = 0x0807060504030201, out_b = 0x1716151413121110, out_count = 8.
REQ-035 SHALL cover: 3 accepts (a = 0xFF) then flush -> out_a = 0x0000000000FFFFFF, out_count = 3.
REQ-036 SHALL cover: out_ready = 0 with a full vector held -> in_ready = 0, outputs stable for 5 cycles; then out_ready = 1 with in_valid = 1 -> new element lands in lane 0, other lanes 0.
REQ-037 SHALL cover: flush with the lane count at 0 and no element -> out_valid stays 0; flush coinciding with the 8th element -> out_count = 8 and exactly one vector.
REQ-038 SHALL cover: reset_n pulsed low after 5 accepts -> out_valid = 0, then 8 fresh accepts produce exactly one vector containing only the new data.
REQ-039 SHALL cover: a back-to-back stream of 24 elements with out_ready = 1 -> 3 vectors, with in_ready held at 1 throughout.
